sub_256bit_seq: RTL and testbench

SUB_256BIT_SEQ -- requirements
Module: sub_256bit_seq

---
 rtl/sub_256bit_seq_pkg.sv | 20 ++
 rtl/sub_256bit_seq_slice.sv | 30 +++
 rtl/sub_256bit_seq.sv | 136 +++++++++++++
 tb/tb_sub_256bit_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_256bit_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sub_256bit_seq_pkg                                                |
// | Purpose  : Shared definitions for the sequential 256-bit subtractor:        |
// |            operand width constant and the control FSM state encoding.      |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package sub_256bit_seq_pkg;

  localparam int DATA_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : sub_256bit_seq_pkg
`default_nettype wire

// File: rtl/sub_256bit_seq_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sub_slice                                                       |
// | Purpose  : Combinational W-bit subtract-with-borrow: d = a - b - bin.      |
// | Ports    : a, b    (in,  W) minuend / subtrahend slice                      |
// |            bin     (in,  1) borrow in                                      |
// |            d       (out, W) difference slice                               |
// |            bout    (out, 1) borrow out (result went negative)              |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sub_slice #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  // One extra bit of headroom: the top bit of the W+1 bit result is set
  // exactly when a - b - bin is negative, i.e. a borrow leaves this slice.
  logic [W:0] diff;

  assign diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign d    = diff[W-1:0];
  assign bout = diff[W];

endmodule : sub_slice
`default_nettype wire

// File: rtl/sub_256bit_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sub_256bit_seq                                                  |
// | Purpose  : 256-bit unsigned subtractor, SLICE_W bits per cycle, LSB first, |
// |            with valid/ready handshakes on both operand and result sides.   |
// | Ports    : clk, rst_n          clock / async active-low reset              |
// |            in_valid, in_ready  operand handshake                           |
// |            din1, din2, bin     minuend, subtrahend, borrow in              |
// |            out_valid, out_ready result handshake                           |
// |            dout, bout, zero    difference, borrow out, dout==0 flag        |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sub_256bit_seq
  import sub_256bit_seq_pkg::*;
#(
  parameter int SLICE_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic              bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              bout,
  output logic              zero
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  state_e            state_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic              borrow_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              bout_q;
  logic              zero_q;

  logic [SLICE_W-1:0] slice_d;
  logic               slice_bout;
  logic [DATA_W-1:0]  res_shift;

  // Operands are shifted right every CALC cycle, so the active slice is
  // always the low SLICE_W bits and no variable part-select is needed.
  sub_slice #(
    .W (SLICE_W)
  ) u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .bin  (borrow_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // Result register is filled from the top: each new slice enters at the
  // MSB end, so after NSLICE cycles the LSB slice has reached bit 0.
  generate
    if (NSLICE == 1) begin : g_single_slice
      assign res_shift = slice_d;
    end else begin : g_multi_slice
      assign res_shift = {slice_d, res_q[DATA_W-1:SLICE_W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= din1;
            b_q        <= din2;
            borrow_q   <= bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          a_q      <= a_q >> SLICE_W;
          b_q      <= b_q >> SLICE_W;
          borrow_q <= slice_bout;
          res_q    <= res_shift;
          if (cnt_q == LAST_SLICE) begin
            // Flags come from the complete result as it is being written.
            bout_q      <= slice_bout;
            zero_q      <= (res_shift == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // Return to IDLE only; the next accept is a cycle later.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = res_q;
  assign bout      = bout_q;
  assign zero      = zero_q;

endmodule : sub_256bit_seq
`default_nettype wire

// File: tb/tb_sub_256bit_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sub_256bit_seq                                               |
// | Purpose  : Self-checking bench for sub_256bit_seq (SLICE_W = 64): directed |
// |            vector table, randomized ops vs. arithmetic model, reset abort |
// |            and back-to-back throughput sequences.                          |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sub_256bit_seq;

  localparam int W       = 256;
  localparam int LATENCY = 4;
  localparam int ISSUE   = 6;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din1;
  logic [W-1:0] din2;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  logic         bout;
  logic         zero;

  sub_256bit_seq #(
    .SLICE_W (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din1      (din1),
    .din2      (din2),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .bout      (bout),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    int           hold;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: plain modular subtraction and a full-precision comparison.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       output logic [W-1:0] d, output logic bo, output logic z);
    logic [W:0] rhs;
    d   = a - b - W'(bi);
    rhs = {1'b0, b} + (W+1)'(bi);
    bo  = ({1'b0, a} < rhs);
    z   = (d == '0);
  endtask

  // Issue one op, check latency, results, hold stability, and handshake.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input logic [W-1:0] ed, input logic ebo,
                        input logic ez, input int hold);
    int n;
    n = 0;
    out_ready = 1'b0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    din1 = a; din2 = b; bin = bi; in_valid = 1'b1;
    @(negedge clk);
    // Accepted; scramble inputs to prove they were captured.
    in_valid = 1'b0;
    din1 = rand256(); din2 = rand256(); bin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, W'(n), W'(LATENCY));
    chk({tag, "_dout"}, dout, ed);
    chk({tag, "_flags"}, W'({bout, zero, in_ready}), W'({ebo, ez, 1'b0}));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_dout"}, dout, ed);
      chk({tag, "_hold_flags"}, W'({out_valid, in_ready, bout, zero}), W'({1'b1, 1'b0, ebo, ez}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_hs"}, W'({in_ready, out_valid}), W'({1'b1, 1'b0}));
  endtask

  initial begin
    vec_t         vecs[$];
    vec_t         v;
    logic [W-1:0] md;
    logic         mbo;
    logic         mz;
    logic [W-1:0] ones;
    logic [W-1:0] a5;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbi;
    exp_t         q[$];
    exp_t         e;
    int           last_v;
    int           n_res;
    int           seen;

    ones = '1;
    a5   = {32{8'hA5}};
    vecs.push_back('{a: W'(5), b: W'(3), bi: 1'b0, d: W'(2), bo: 1'b0, z: 1'b0, hold: 0});
    vecs.push_back('{a: '0, b: W'(1), bi: 1'b0, d: ones, bo: 1'b1, z: 1'b0, hold: 0});
    vecs.push_back('{a: W'(1) << 64, b: '0, bi: 1'b1, d: W'(64'hFFFF_FFFF_FFFF_FFFF),
                     bo: 1'b0, z: 1'b0, hold: 0});
    vecs.push_back('{a: a5, b: a5, bi: 1'b0, d: '0, bo: 1'b0, z: 1'b1, hold: 10});
    vecs.push_back('{a: '0, b: '0, bi: 1'b1, d: ones, bo: 1'b1, z: 1'b0, hold: 0});
    vecs.push_back('{a: ones, b: ones, bi: 1'b1, d: ones, bo: 1'b1, z: 1'b0, hold: 2});
    vecs.push_back('{a: '0, b: '0, bi: 1'b0, d: '0, bo: 1'b0, z: 1'b1, hold: 0});
    vecs.push_back('{a: ones, b: '0, bi: 1'b1, d: ones - W'(1), bo: 1'b0, z: 1'b0, hold: 0});

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din1 = '0; din2 = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", W'({in_ready, out_valid, bout, zero}), W'(4'b1000));
    chk("reset_dout", dout, '0);
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      v = vecs[i];
      run_op($sformatf("vec%0d", i), v.a, v.b, v.bi, v.d, v.bo, v.z, v.hold);
    end

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      ra = rand256(); rb = rand256(); rbi = 1'($urandom);
      case ($urandom_range(0, 4))
        0: rb = ra;
        1: rb = ra + W'($urandom_range(0, 1));
        2: ra[W-1:64] = '0;
        default: ;
      endcase
      model(ra, rb, rbi, md, mbo, mz);
      run_op($sformatf("rnd%0d", i), ra, rb, rbi, md, mbo, mz, $urandom_range(0, 2));
    end

    // Reset in the middle of CALC discards the operation.
    din1 = W'(100); din2 = W'(1); bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", W'({in_ready, out_valid, bout, zero}), W'(4'b1000));
    chk("rst_mid_dout", dout, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_valid", W'(seen), W'(0));
    run_op("post_rst", W'(7), W'(3), 1'b0, W'(4), 1'b0, 1'b0, 0);

    // Accept on the first edge after reset release.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    din1 = W'(9); din2 = W'(9); bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("first_edge_accept", W'(in_ready), W'(0));
    repeat (LATENCY) @(negedge clk);
    chk("first_edge_result", W'({out_valid, zero}), W'(2'b11));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Back-to-back throughput with in_valid and out_ready held high.
    last_v = -1; n_res = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("b2b_in_ready_low", W'(in_ready), W'(0));
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("b2b_dout", dout, e.d);
          chk("b2b_bout", W'(bout), W'(e.bo));
        end else begin
          chk("b2b_unexpected", W'(out_valid), W'(0));
        end
        if (last_v >= 0) chk("b2b_gap", W'(cyc - last_v), W'(ISSUE));
        last_v = cyc;
        n_res++;
      end
      in_valid = (cyc < 30);
      din1 = rand256(); din2 = rand256(); bin = 1'($urandom);
      if (in_valid && in_ready) begin
        model(din1, din2, bin, md, mbo, mz);
        q.push_back('{d: md, bo: mbo});
      end
    end
    out_ready = 1'b0;
    chk("b2b_drained", W'(q.size()), W'(0));
    chk("b2b_results", W'(n_res >= 4), W'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_sub_256bit_seq
`default_nettype wire
